gpio_in_capture: RTL and testbench
==================================

# gpio_in_capture

Pad-input side of the openframe GPIO path. Takes raw `gpio_in` from the pad ring and produces clean signals for the core. It synchronizes each pin into `mclk` and debounces it per pin. It then detects rising and falling edges and keeps sticky, maskable interrupt status with a single aggregated interrupt line.

## Interface
Parameters:
- `OPENFRAME_IO_PADS`, 19: number of pads handled.
- `DEB_CNT_W`, 8: width of the per-pin debounce counter and of the limit field.

Ports:
- `mclk`  in  1  core clock; single clock domain for all state.
- `rst`  in  1  reset; synchronous, active-high.
- `gpio_in`  in  N  raw pad inputs, asynchronous to `mclk`.
- `cfg_deb_limit`  in  DEB_CNT_W  debounce length in cycles; shared by all pins.
- `cfg_posedge_en`  in  N  per-pin rising-edge event enable.
- `cfg_negedge_en`  in  N  per-pin falling-edge event enable.
- `cfg_int_mask`  in  N  per-pin interrupt enable (1 = contributes to `gpio_irq`).
- `int_clr`  in  N  write-1-to-clear pulse for `gpio_int_stat`.
- `gpio_data`  out  N  debounced pin level.
- `gpio_int_stat`  out  N  sticky edge-event status.
- `gpio_irq`  out  1  registered OR of `gpio_int_stat & cfg_int_mask`.

(N = `OPENFRAME_IO_PADS`.)

## Operation
Per pin, all logic is identical and independent.
- Synchronizer: two flops, `sync1 <= gpio_in`, `sync2 <= sync1`. No logic between them.
- Debounce state: `stable` bit and `cnt` counter of width DEB_CNT_W.
  - When `sync2 == stable`: `cnt <= 0`.
  - When `sync2 != stable` and `cnt >= cfg_deb_limit`: `stable <= sync2`, `cnt <= 0`. This is the update event.
  - When `sync2 != stable` and `cnt < cfg_deb_limit`: `cnt <= cnt + 1`. The counter cannot wrap, because the update condition fires first.
  - The compare uses `>=`. If `cfg_deb_limit` is lowered mid-count, the update fires on the next cycle.
- `gpio_data = stable`, driven directly from the flop.
- Edge event, asserted in the cycle of an update:
  - rise = update & `sync2` & `cfg_posedge_en`
  - fall = update & `!sync2` & `cfg_negedge_en`
- Status: `gpio_int_stat <= (gpio_int_stat & ~int_clr) | rise | fall`.
  - Set wins over a simultaneous clear.
  - `cfg_int_mask` does not gate status; it gates only `gpio_irq`.
- `gpio_irq <= |(gpio_int_stat & cfg_int_mask)`.
- A glitch on `sync2` shorter than `cfg_deb_limit + 1` cycles is filtered: `cnt` returns to 0 and no event is raised.
- The first update after reset is a real event. A pin held high through reset reports a rising edge if `cfg_posedge_en` is set.

## Timing
- Reset values: `sync1`, `sync2`, `stable`, `cnt`, `gpio_data`, `gpio_int_stat`, `gpio_irq` are all 0.
- Reset is synchronous; an assertion mid-debounce discards the count and the status.
- Define edge 1 as the first `mclk` edge after `gpio_in` changes and is then held.
  - `sync2` changes at edge 2.
  - `gpio_data` and `gpio_int_stat` update at edge 3 + `cfg_deb_limit`.
  - `gpio_irq` rises one edge later, at edge 4 + `cfg_deb_limit`.
- `cfg_deb_limit = 0` gives the minimum latency: 3 edges to data, 4 edges to irq.
- `int_clr` takes effect at the next edge; `gpio_irq` falls one edge after that.
- Mask changes reach `gpio_irq` in 1 cycle.
- All `cfg_*` inputs are quasi-static. They are sampled every cycle and not synchronized.

## Configuration
- `GPIO_DEBOUNCE_EN`:
  - Defined: debounce counters are implemented as described above.
  - Undefined: no `cnt` registers exist and `cfg_deb_limit` is ignored. `stable <= sync2` every cycle, and an update event is any cycle where `sync2 != stable`. Latency equals the `cfg_deb_limit = 0` case (data at edge 3, irq at edge 4).

## Test plan
- Reset with `gpio_in = 0`: after `rst` is released, all outputs read 0.
- Clean rise, limit 0: `cfg_deb_limit = 0`, posedge_en[3] = 1, mask[3] = 1, drive `gpio_in[3] = 1`.
  - Required: `gpio_data[3] = 1` and `gpio_int_stat[3] = 1` at edge 3; `gpio_irq = 1` at edge 4.
- Glitch filtering: `cfg_deb_limit = 10`, pulse `gpio_in[0]` high for 5 cycles.
  - Required: `gpio_data[0]` stays 0 and no status is set.
  - Then hold it high: `gpio_data[0] = 1` at edge 13.
- Edge enables: negedge_en[7] = 1, posedge_en[7] = 0, `cfg_deb_limit = 2`, drive `gpio_in[7]` 0→1→0 with long holds.
  - Required: no status on the rise; `gpio_int_stat[7]` sets 5 edges after the fall.
- Set/clear collision: pulse `int_clr[5] = 1` in the same cycle as a rise event on pin 5.
  - Required: status stays 1. A later `int_clr` alone clears it, and `gpio_irq` drops 1 cycle after that.
- Masking and reset mid-count: set status on pin 2 with mask[2] = 0.
  - Required: `gpio_irq` stays 0; setting mask[2] = 1 raises it next cycle.
  - Assert `rst` while a `cfg_deb_limit = 50` count is in progress: all state reads 0 next cycle.

Source files
------------

// File: rtl/gpio_in_capture.sv
// Pad-input capture: per-pin 2-flop synchronizer, optional debounce, edge detect,
// sticky W1C status and masked IRQ. Define GPIO_DEBOUNCE_EN to build the debounce counters.
module gpio_in_capture #(
    parameter int OPENFRAME_IO_PADS = 19,
    parameter int DEB_CNT_W         = 8
) (
    input  logic                         mclk,
    input  logic                         rst,
    input  logic [OPENFRAME_IO_PADS-1:0] gpio_in,
    input  logic [DEB_CNT_W-1:0]         cfg_deb_limit,
    input  logic [OPENFRAME_IO_PADS-1:0] cfg_posedge_en,
    input  logic [OPENFRAME_IO_PADS-1:0] cfg_negedge_en,
    input  logic [OPENFRAME_IO_PADS-1:0] cfg_int_mask,
    input  logic [OPENFRAME_IO_PADS-1:0] int_clr,
    output logic [OPENFRAME_IO_PADS-1:0] gpio_data,
    output logic [OPENFRAME_IO_PADS-1:0] gpio_int_stat,
    output logic                         gpio_irq
);

    localparam int N = OPENFRAME_IO_PADS;

    logic [N-1:0] sync1_q, sync2_q;
    logic [N-1:0] stable_q, stable_d;
    logic [N-1:0] stat_q, stat_d;
    logic         irq_q, irq_d;
    logic [N-1:0] update, rise, fall;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge mclk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [DEB_CNT_W-1:0] cnt_q [N];
    logic [DEB_CNT_W-1:0] cnt_d [N];

    // NOTE: defaults first in always_comb so no path leaves a signal unassigned (no latch).
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i]  = '0;
            update[i] = 1'b0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] >= cfg_deb_limit) begin
                    update[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + DEB_CNT_W'(1);
                end
            end
        end
    end

    // NOTE: counter array is reset explicitly; it is flop state, not a RAM.
    always_ff @(posedge mclk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_deb_limit;
    assign unused_deb_limit = ^cfg_deb_limit;
    assign update           = sync2_q ^ stable_q;
`endif

    // An update adopts the synchronized level; edge direction is the new level.
    assign stable_d = (stable_q & ~update) | (sync2_q & update);
    assign rise     = update & sync2_q & cfg_posedge_en;
    assign fall     = update & ~sync2_q & cfg_negedge_en;
    assign stat_d   = (stat_q & ~int_clr) | rise | fall;
    assign irq_d    = |(stat_q & cfg_int_mask);

    always_ff @(posedge mclk) begin
        if (rst) begin
            stable_q <= '0;
            stat_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            stable_q <= stable_d;
            stat_q   <= stat_d;
            irq_q    <= irq_d;
        end
    end

    assign gpio_data     = stable_q;
    assign gpio_int_stat = stat_q;
    assign gpio_irq      = irq_q;

endmodule

// File: tb/tb_gpio_in_capture.sv
// Directed bench for gpio_in_capture; expectations follow GPIO_DEBOUNCE_EN when defined.
module tb_gpio_in_capture;

    localparam int N = 19;
    localparam int W = 8;
`ifdef GPIO_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif

    logic         mclk;
    logic         rst;
    logic [N-1:0] gpio_in;
    logic [W-1:0] cfg_deb_limit;
    logic [N-1:0] cfg_posedge_en, cfg_negedge_en, cfg_int_mask, int_clr;
    logic [N-1:0] gpio_data, gpio_int_stat;
    logic         gpio_irq;

    int checks = 0;
    int errors = 0;

    gpio_in_capture #(.OPENFRAME_IO_PADS(N), .DEB_CNT_W(W)) dut (
        .mclk          (mclk),
        .rst           (rst),
        .gpio_in       (gpio_in),
        .cfg_deb_limit (cfg_deb_limit),
        .cfg_posedge_en(cfg_posedge_en),
        .cfg_negedge_en(cfg_negedge_en),
        .cfg_int_mask  (cfg_int_mask),
        .int_clr       (int_clr),
        .gpio_data     (gpio_data),
        .gpio_int_stat (gpio_int_stat),
        .gpio_irq      (gpio_irq)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Inputs change and outputs are sampled on the falling edge; tick(k) lands after rising edge k.
    task automatic tick(input int n);
        repeat (n) @(negedge mclk);
    endtask

    function automatic int lat(input int lim);
        return DEB_ON ? 3 + lim : 3;
    endfunction

    task automatic clear_all();
        int_clr = '1;
        tick(1);
        int_clr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; gpio_in = '0; cfg_deb_limit = '0;
        cfg_posedge_en = '0; cfg_negedge_en = '0; cfg_int_mask = '0; int_clr = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++; if (gpio_data !== '0) begin errors++; $display("FAIL reset_data: got %h exp 0", gpio_data); end
        checks++; if (gpio_int_stat !== '0) begin errors++; $display("FAIL reset_stat: got %h exp 0", gpio_int_stat); end
        checks++; if (gpio_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b exp 0", gpio_irq); end
    endtask

    task automatic test_clean_rise();
        cfg_deb_limit = 8'd0;
        cfg_posedge_en = '0; cfg_posedge_en[3] = 1'b1;
        cfg_int_mask = '0;   cfg_int_mask[3] = 1'b1;
        gpio_in[3] = 1'b1;
        tick(2);
        checks++; if (gpio_data[3] !== 1'b0) begin errors++; $display("FAIL rise_data_e2: got %b exp 0", gpio_data[3]); end
        tick(1);
        checks++; if (gpio_data[3] !== 1'b1) begin errors++; $display("FAIL rise_data_e3: got %b exp 1", gpio_data[3]); end
        checks++; if (gpio_int_stat[3] !== 1'b1) begin errors++; $display("FAIL rise_stat_e3: got %b exp 1", gpio_int_stat[3]); end
        checks++; if (gpio_irq !== 1'b0) begin errors++; $display("FAIL rise_irq_e3: got %b exp 0", gpio_irq); end
        tick(1);
        checks++; if (gpio_irq !== 1'b1) begin errors++; $display("FAIL rise_irq_e4: got %b exp 1", gpio_irq); end
    endtask

    task automatic test_glitch();
        logic exp_mid;
        cfg_int_mask = '0;
        cfg_posedge_en = '0; cfg_posedge_en[0] = 1'b1;
        cfg_deb_limit = 8'd10;
        clear_all();
        exp_mid = ~DEB_ON;
        gpio_in[0] = 1'b1;
        tick(4);
        checks++; if (gpio_data[0] !== exp_mid) begin errors++; $display("FAIL glitch_data_mid: got %b exp %b", gpio_data[0], exp_mid); end
        tick(1);
        gpio_in[0] = 1'b0;
        tick(20);
        checks++; if (gpio_data[0] !== 1'b0) begin errors++; $display("FAIL glitch_data_after: got %b exp 0", gpio_data[0]); end
        checks++; if (gpio_int_stat[0] !== exp_mid) begin errors++; $display("FAIL glitch_stat: got %b exp %b", gpio_int_stat[0], exp_mid); end
        clear_all();
        gpio_in[0] = 1'b1;
        tick(lat(10) - 1);
        checks++; if (gpio_data[0] !== 1'b0) begin errors++; $display("FAIL hold_data_early: got %b exp 0", gpio_data[0]); end
        tick(1);
        checks++; if (gpio_data[0] !== 1'b1) begin errors++; $display("FAIL hold_data: got %b exp 1", gpio_data[0]); end
        checks++; if (gpio_int_stat[0] !== 1'b1) begin errors++; $display("FAIL hold_stat: got %b exp 1", gpio_int_stat[0]); end
    endtask

    task automatic test_edge_enables();
        cfg_posedge_en = '0;
        cfg_negedge_en = '0; cfg_negedge_en[7] = 1'b1;
        cfg_deb_limit = 8'd2;
        clear_all();
        gpio_in[7] = 1'b1;
        tick(12);
        checks++; if (gpio_data[7] !== 1'b1) begin errors++; $display("FAIL en_rise_data: got %b exp 1", gpio_data[7]); end
        checks++; if (gpio_int_stat[7] !== 1'b0) begin errors++; $display("FAIL en_rise_stat: got %b exp 0", gpio_int_stat[7]); end
        gpio_in[7] = 1'b0;
        tick(lat(2) - 1);
        checks++; if (gpio_int_stat[7] !== 1'b0) begin errors++; $display("FAIL en_fall_stat_early: got %b exp 0", gpio_int_stat[7]); end
        tick(1);
        checks++; if (gpio_int_stat[7] !== 1'b1) begin errors++; $display("FAIL en_fall_stat: got %b exp 1", gpio_int_stat[7]); end
        checks++; if (gpio_data[7] !== 1'b0) begin errors++; $display("FAIL en_fall_data: got %b exp 0", gpio_data[7]); end
    endtask

    task automatic test_set_clear_collision();
        cfg_deb_limit = 8'd0;
        cfg_negedge_en = '0;
        cfg_posedge_en = '0; cfg_posedge_en[5] = 1'b1;
        cfg_int_mask = '0;   cfg_int_mask[5] = 1'b1;
        clear_all();
        tick(1);
        checks++; if (gpio_irq !== 1'b0) begin errors++; $display("FAIL coll_irq_idle: got %b exp 0", gpio_irq); end
        gpio_in[5] = 1'b1;
        tick(2);
        int_clr[5] = 1'b1;
        tick(1);
        int_clr[5] = 1'b0;
        checks++; if (gpio_int_stat[5] !== 1'b1) begin errors++; $display("FAIL coll_set_wins: got %b exp 1", gpio_int_stat[5]); end
        tick(1);
        checks++; if (gpio_irq !== 1'b1) begin errors++; $display("FAIL coll_irq_set: got %b exp 1", gpio_irq); end
        int_clr[5] = 1'b1;
        tick(1);
        int_clr[5] = 1'b0;
        checks++; if (gpio_int_stat[5] !== 1'b0) begin errors++; $display("FAIL coll_clear: got %b exp 0", gpio_int_stat[5]); end
        checks++; if (gpio_irq !== 1'b1) begin errors++; $display("FAIL coll_irq_lag: got %b exp 1", gpio_irq); end
        tick(1);
        checks++; if (gpio_irq !== 1'b0) begin errors++; $display("FAIL coll_irq_drop: got %b exp 0", gpio_irq); end
    endtask

    task automatic test_mask();
        cfg_deb_limit = 8'd0;
        cfg_posedge_en = '0; cfg_posedge_en[2] = 1'b1;
        cfg_int_mask = '0;
        clear_all();
        gpio_in[2] = 1'b1;
        tick(5);
        checks++; if (gpio_int_stat[2] !== 1'b1) begin errors++; $display("FAIL mask_stat: got %b exp 1", gpio_int_stat[2]); end
        checks++; if (gpio_irq !== 1'b0) begin errors++; $display("FAIL mask_irq_off: got %b exp 0", gpio_irq); end
        cfg_int_mask[2] = 1'b1;
        tick(1);
        checks++; if (gpio_irq !== 1'b1) begin errors++; $display("FAIL mask_irq_on: got %b exp 1", gpio_irq); end
    endtask

    task automatic test_reset_mid_count();
        logic exp_pre;
        cfg_deb_limit = 8'd50;
        cfg_posedge_en = '0; cfg_posedge_en[4] = 1'b1;
        cfg_int_mask = '0;
        exp_pre = ~DEB_ON;
        gpio_in[4] = 1'b1;
        tick(10);
        checks++; if (gpio_data[4] !== exp_pre) begin errors++; $display("FAIL midcnt_data_pre: got %b exp %b", gpio_data[4], exp_pre); end
        rst = 1'b1;
        tick(1);
        checks++; if (gpio_data !== '0) begin errors++; $display("FAIL midcnt_rst_data: got %h exp 0", gpio_data); end
        checks++; if (gpio_int_stat !== '0) begin errors++; $display("FAIL midcnt_rst_stat: got %h exp 0", gpio_int_stat); end
        checks++; if (gpio_irq !== 1'b0) begin errors++; $display("FAIL midcnt_rst_irq: got %b exp 0", gpio_irq); end
        cfg_deb_limit = 8'd0;
        tick(1);
        rst = 1'b0;
        tick(2);
        checks++; if (gpio_data[4] !== 1'b0) begin errors++; $display("FAIL post_rst_data_e2: got %b exp 0", gpio_data[4]); end
        tick(1);
        checks++; if (gpio_data[4] !== 1'b1) begin errors++; $display("FAIL post_rst_data_e3: got %b exp 1", gpio_data[4]); end
        checks++; if (gpio_int_stat[4] !== 1'b1) begin errors++; $display("FAIL post_rst_stat_e3: got %b exp 1", gpio_int_stat[4]); end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_edge_enables();
        test_set_clear_collision();
        test_mask();
        test_reset_mid_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
